// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with 50% duty for even and odd ratios.
// The divisor goes through a pending (shadow) register and is applied only
// when a new output period starts, so ratio changes and enable changes never
// produce a runt or glitch on clk_o.
//
// FSM states
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_PARK  | idle, cnt held at 0, clk_o low; every cycle is a boundary
//   ST_RUN   | producing periods, cnt counts 0..N-1, boundary at cnt==N-1
`timescale 1ns/1ps
module clk_div_prog #(
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic             div_ack_o
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    typedef enum logic {
        ST_PARK = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] active_q, active_d;
    logic [DIV_W-1:0] pending_q, pending_d;
    logic             p_q, p_d;
    logic             n_q;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             boundary;

    logic [DIV_W-1:0] div_clamped;
    logic [DIV_W-1:0] half;
    logic [DIV_W-1:0] cnt_inc;
    logic             at_wrap;

    // Divisors 0 and 1 cannot give a 50% waveform, so they fold to 2.
    assign div_clamped = (div_i < DIV_MIN) ? DIV_MIN : div_i;
    assign half        = active_q >> 1;
    assign cnt_inc     = cnt_q + ONE;
    assign at_wrap     = (cnt_q == (active_q - ONE));

    // Next-state, counter, shadow register and registered-output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        pending_d = load_i ? div_clamped : pending_q;
        p_d       = 1'b0;
        tick_d    = 1'b0;
        ack_d     = 1'b0;
        boundary  = 1'b1;

        unique case (state_q)
            ST_PARK: boundary = 1'b1;
            ST_RUN:  boundary = at_wrap;
            default: boundary = 1'b1;
        endcase

        if (boundary) begin
            // A load in this same cycle only reaches pending_d, so the
            // divisor applied here is always the one captured earlier.
            cnt_d = '0;
            if (en_i) begin
                state_d = ST_RUN;
                p_d     = 1'b1;
                tick_d  = 1'b1;
                if (pending_q != active_q) begin
                    active_d = pending_q;
                    ack_d    = 1'b1;
                end
            end else begin
                state_d = ST_PARK;
            end
        end else begin
            cnt_d = cnt_inc;
            p_d   = (cnt_inc < half);
        end
    end

    // Rising-edge state: counter, divisors, phase flop p and strobes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_PARK;
            cnt_q     <= '0;
            active_q  <= DIV_RST;
            pending_q <= DIV_RST;
            p_q       <= 1'b0;
            tick_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            p_q       <= p_d;
            tick_q    <= tick_d;
            ack_q     <= ack_d;
        end
    end

    // Falling-edge copy of p; stretches the high phase by half a cycle for odd N.
    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            n_q <= 1'b0;
        end else begin
            n_q <= p_q;
        end
    end

    // Odd/even select switches only at period start, when p has just risen
    // and n is still low, so both terms agree and no glitch is possible.
    assign clk_o     = active_q[0] ? (p_q | n_q) : p_q;
    assign tick_o    = tick_q;
    assign div_ack_o = ack_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios followed by
// randomized load/enable/reset traffic, compared half-cycle by half-cycle
// against a period-position reference model.
`timescale 1ns/1ps
module tb_clk_div_prog;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       en_i;
    logic       load_i;
    logic [7:0] div_i;
    logic       clk_o;
    logic       tick_o;
    logic       div_ack_o;

    int n_tests = 0;
    int n_fail  = 0;

    clk_div_prog #(.DIV_W(8), .DIV_DEFAULT(6)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .load_i    (load_i),
        .div_i     (div_i),
        .clk_o     (clk_o),
        .tick_o    (tick_o),
        .div_ack_o (div_ack_o)
    );

    always #5 clk_i = ~clk_i;

    // reference model: where we are inside the output period
    bit m_run  = 1'b0;
    int m_pos  = 0;
    int m_n    = 6;
    int m_pend = 6;
    bit m_tick = 1'b0;
    bit m_ack  = 1'b0;

    int tick_cnt = 0;
    int ack_cnt  = 0;

    realtime last_edge   = 0.0;
    realtime last_high_w = 0.0;
    realtime last_low_w  = 0.0;
    realtime last_fall_t = 0.0;
    bit      have_last   = 1'b0;
    bit      glitch_armed = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp_div(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic model_edge();
        bit bnd;
        m_tick = 1'b0;
        m_ack  = 1'b0;
        if (rst_i) begin
            m_run  = 1'b0;
            m_pos  = 0;
            m_n    = 6;
            m_pend = 6;
        end else begin
            bnd = !m_run || (m_pos == m_n - 1);
            if (bnd) begin
                m_pos = 0;
                if (en_i) begin
                    m_run  = 1'b1;
                    m_tick = 1'b1;
                    if (m_pend != m_n) begin
                        m_n   = m_pend;
                        m_ack = 1'b1;
                    end
                end else begin
                    m_run = 1'b0;
                end
            end else begin
                m_pos++;
            end
            if (load_i) m_pend = clamp_div(int'(div_i));
        end
    endtask

    // High while the half-cycle index within the period is below N.
    task automatic step();
        bit rst_edge;
        @(posedge clk_i);
        rst_edge = rst_i;
        model_edge();
        #2;
        check("tick", tick_o, m_tick);
        check("ack", div_ack_o, m_ack);
        if (!rst_edge) check("clk_rise_half", clk_o, m_run && (2 * m_pos < m_n));
        tick_cnt += int'(tick_o);
        ack_cnt  += int'(div_ack_o);
        @(negedge clk_i);
        #2;
        check("clk_fall_half", clk_o, m_run && (2 * m_pos + 1 < m_n));
    endtask

    // Pulse-width watcher: no legal phase is shorter than one clk_i cycle.
    always @(clk_o) begin
        realtime w;
        if (have_last) begin
            w = $realtime - last_edge;
            if (glitch_armed) check("pulse_width", (w >= 10.0), 1'b1);
            if (clk_o) last_low_w = w;
            else begin
                last_high_w = w;
                last_fall_t = $realtime;
            end
        end
        have_last = 1'b1;
        last_edge = $realtime;
    end

    task automatic load_div(input int d);
        load_i = 1'b1;
        div_i  = 8'(d);
        step();
        load_i = 1'b0;
    endtask

    initial begin
        int g;
        rst_i  = 1'b1;
        en_i   = 1'b1;
        load_i = 1'b0;
        div_i  = '0;

        // reset state
        repeat (3) step();
        check("rst_clk", clk_o, 1'b0);
        check("rst_tick", tick_o, 1'b0);
        check("rst_ack", div_ack_o, 1'b0);
        rst_i = 1'b0;
        glitch_armed = 1'b1;

        // default N=6
        tick_cnt = 0; ack_cnt = 0;
        repeat (30) step();
        check("s1_ticks", tick_cnt, 5);
        check("s1_acks", ack_cnt, 0);
        check("s1_high_ns", int'(last_high_w), 30);
        check("s1_low_ns", int'(last_low_w), 30);

        // N=5 loaded mid-period
        repeat (2) step();
        ack_cnt = 0;
        load_div(5);
        repeat (30) step();
        check("s2_acks", ack_cnt, 1);
        check("s2_high_ns", int'(last_high_w), 25);
        check("s2_low_ns", int'(last_low_w), 25);
        check("s2_fall_align", int'(last_fall_t) % 10, 0);

        // clamping and maximum divisor
        load_div(0);
        repeat (20) step();
        check("s3_d0_high_ns", int'(last_high_w), 10);
        check("s3_d0_low_ns", int'(last_low_w), 10);
        ack_cnt = 0;
        load_div(1);
        repeat (20) step();
        check("s3_d1_acks", ack_cnt, 0);
        check("s3_d1_high_ns", int'(last_high_w), 10);
        load_div(255);
        repeat (600) step();
        check("s3_d255_high_ns", int'(last_high_w), 1275);
        check("s3_d255_low_ns", int'(last_low_w), 1275);

        // two loads in one period: last one wins
        ack_cnt = 0;
        load_div(7);
        step();
        load_div(3);
        repeat (200) step();
        check("s4_acks", ack_cnt, 1);
        check("s4_high_ns", int'(last_high_w), 15);
        check("s4_low_ns", int'(last_low_w), 15);

        // load exactly on a boundary edge goes to the following boundary
        g = 0;
        while (m_pos != m_n - 1 && g < 20) begin step(); g++; end
        check("bnd_sync", (g < 20), 1'b1);
        ack_cnt = 0;
        load_div(4);
        check("bnd_no_ack_now", div_ack_o, 1'b0);
        repeat (12) step();
        check("bnd_acks", ack_cnt, 1);
        check("bnd_high_ns", int'(last_high_w), 20);

        // enable dropped in cycle 1 of a 6-cycle period
        load_div(6);
        repeat (20) step();
        g = 0;
        while (m_pos != 1 && g < 20) begin step(); g++; end
        check("s5_sync", (g < 20), 1'b1);
        en_i = 1'b0;
        tick_cnt = 0;
        repeat (20) step();
        check("s5_parked_ticks", tick_cnt, 0);
        check("s5_parked_clk", clk_o, 1'b0);
        check("s5_last_high_ns", int'(last_high_w), 30);
        en_i = 1'b1;
        step();
        check("s5_restart_tick", tick_o, 1'b1);
        repeat (20) step();
        check("s5_high_ns", int'(last_high_w), 30);

        // reset in the high phase of an N=5 period
        load_div(5);
        g = 0;
        while (!(m_n == 5 && m_pos == 1) && g < 40) begin step(); g++; end
        check("s6_sync", (g < 40), 1'b1);
        rst_i = 1'b1;
        step();
        check("s6_clk_low", clk_o, 1'b0);
        rst_i = 1'b0;
        tick_cnt = 0; ack_cnt = 0;
        repeat (30) step();
        check("s6_ticks", tick_cnt, 5);
        check("s6_acks", ack_cnt, 0);
        check("s6_high_ns", int'(last_high_w), 30);
        check("s6_low_ns", int'(last_low_w), 30);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            en_i   = ($urandom_range(0, 19) != 0);
            load_i = ($urandom_range(0, 9) == 0);
            div_i  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                 : 8'($urandom_range(0, 12));
            rst_i  = ($urandom_range(0, 399) == 0);
            step();
        end
        rst_i  = 1'b0;
        load_i = 1'b0;
        en_i   = 1'b1;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
